// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, a few opcode/funct
// constants, default fetch parameters and a field-splitting helper.
package mips_pkg;

  localparam int WORD_SIZE_DEF = 32;
  localparam int DEPTH_DEF     = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Field bit positions within a 32-bit instruction word
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] jaddr;
  } instr_fields_t;

  // Overlapping R/I/J views of one instruction word
  function automatic instr_fields_t split_fields(input logic [31:0] w);
    instr_fields_t f;
    f.opcode    = w[OPCODE_MSB:OPCODE_LSB];
    f.rs        = w[RS_MSB:RS_LSB];
    f.rt        = w[RT_MSB:RT_LSB];
    f.rd        = w[RD_MSB:RD_LSB];
    f.shamt     = w[SHAMT_MSB:SHAMT_LSB];
    f.funct     = w[FUNCT_MSB:FUNCT_LSB];
    f.immediate = w[IMM_MSB:IMM_LSB];
    f.jaddr     = w[JADDR_MSB:JADDR_LSB];
    return f;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instruction word}. Clear wins over a
// same-cycle push; push and pop together are legal.
module fetch_buffer
  import mips_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [PC_W-1:0]            i_push_pc,
  input  logic [31:0]                i_push_word,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic [PC_W-1:0]            o_head_pc,
  output logic [31:0]                o_head_word,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] r_pc_mem   [DEPTH];
  logic [31:0]     r_word_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Storage write; entries need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_pc_mem[r_wr_ptr]   <= i_push_pc;
      r_word_mem[r_wr_ptr] <= i_push_word;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head_pc   = r_pc_mem[r_rd_ptr];
  assign o_head_word = r_word_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem reads under a
// credit limit, buffers returned words and presents them split into fields.
// A pop whose pc_next is not pc+4 redirects fetch and flushes wrong-path work.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The sender keeps valid and its payload stable until that edge; the
// receiver may drive ready independently of valid. imem_req_addr is the one
// payload allowed to change while stalled, and only because of a redirect.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                   WORD_SIZE = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(RESET_PC_DEF),
  parameter int                   DEPTH     = DEPTH_DEF
)(
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [31:0]          imem_resp_data,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [WORD_SIZE-1:0] id_pc,
  output logic [5:0]           id_opcode,
  output logic [4:0]           id_rs,
  output logic [4:0]           id_rt,
  output logic [4:0]           id_rd,
  output logic [4:0]           id_shamt,
  output logic [5:0]           id_funct,
  output logic [15:0]          id_immediate,
  output logic [25:0]          id_jaddr,
  input  logic [WORD_SIZE-1:0] ex_pc_next
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WORD_SIZE-1:0] r_fetch_pc;    // next address to request
  logic [WORD_SIZE-1:0] r_resp_pc;     // pc of the next kept response
  logic [CW-1:0]        r_outstanding; // accepted requests not yet answered
  logic [CW-1:0]        r_discard;     // upcoming responses that are wrong-path

  logic [WORD_SIZE-1:0] w_head_pc;
  logic [31:0]          w_head_word;
  logic [31:0]          w_head_word_g;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_empty;
  logic [CW:0]          w_credit_sum;
  logic                 w_req_fire;
  logic                 w_pop;
  logic                 w_redirect;
  logic                 w_push;
  logic [WORD_SIZE-1:0] w_target;
  logic [CW-1:0]        w_outstanding_next;
  instr_fields_t        w_fields;

  // Credit: buffered plus in-flight never exceeds DEPTH, so a response always fits
  assign w_credit_sum   = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !rst && (w_credit_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign id_valid   = !w_empty;
  assign w_pop      = id_valid && id_ready;
  assign w_redirect = w_pop && (ex_pc_next != (w_head_pc + WORD_SIZE'(4)));
  assign w_target   = {ex_pc_next[WORD_SIZE-1:2], 2'b00};

  // A response in the redirect cycle is old-path and simply not pushed
  assign w_push = imem_resp_valid && (r_discard == '0) && !w_redirect;
  assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);

  fetch_buffer #(
    .PC_W  (WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_pc   (r_resp_pc),
    .i_push_word (imem_resp_data),
    .i_pop       (w_pop),
    .i_clear     (w_redirect),
    .o_head_pc   (w_head_pc),
    .o_head_word (w_head_word),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // PC, response tracking and discard counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_redirect) begin
        // Everything still in flight, including this cycle's request, is stale
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_discard  <= w_outstanding_next;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + WORD_SIZE'(4);
        if (imem_resp_valid) begin
          if (r_discard != '0) r_discard <= r_discard - CW'(1);
          else                 r_resp_pc <= r_resp_pc + WORD_SIZE'(4);
        end
      end
    end
  end

  // Protocol checks: no unsolicited response, no push into a full buffer
  always_ff @(posedge clk) begin
    if (!rst && imem_resp_valid) assert (r_outstanding != '0);
    if (!rst && w_push) assert (!w_full || w_pop);
  end

  // Field outputs read as zero when nothing is presented
  assign w_head_word_g = w_empty ? '0 : w_head_word;
  assign id_pc         = w_empty ? '0 : w_head_pc;
  assign w_fields      = split_fields(w_head_word_g);
  assign id_opcode     = w_fields.opcode;
  assign id_rs         = w_fields.rs;
  assign id_rt         = w_fields.rt;
  assign id_rd         = w_fields.rd;
  assign id_shamt      = w_fields.shamt;
  assign id_funct      = w_fields.funct;
  assign id_immediate  = w_fields.immediate;
  assign id_jaddr      = w_fields.jaddr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-memory model, directed phases, and a
// per-cycle compare against an architectural model of the fetched stream.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_immediate;
  logic [25:0] id_jaddr;
  logic [31:0] ex_pc_next;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  int          fire_cnt = 0;
  logic        jmp_en   = 1'b0;
  logic [31:0] jmp_from = '0;
  logic [31:0] jmp_to   = '0;
  logic [31:0] pop_log[$];
  int          pop_cyc[$];
  logic [31:0] exp_q[$];

  fetch_unit #(.WORD_SIZE(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_funct(id_funct), .id_immediate(id_immediate),
    .id_jaddr(id_jaddr), .ex_pc_next(ex_pc_next)
  );

  // The execute stage: sequential except for one programmable jump
  assign ex_pc_next = (jmp_en && id_pc == jmp_from) ? jmp_to : id_pc + 32'd4;

  wire [79:0] fields_now = {id_opcode, id_rs, id_rt, id_rd, id_shamt,
                            id_funct, id_immediate, id_jaddr};

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0085_1020;
    return (a * 32'h9E37_79B1) ^ 32'h1234_0000 ^ a;
  endfunction

  function automatic logic [79:0] model_fields(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    return {6'(w >> 26), 5'((w >> 21) & 31), 5'((w >> 16) & 31),
            5'((w >> 11) & 31), 5'((w >> 6) & 31), 6'(w & 63),
            16'(w & 32'hFFFF), 26'(w & 32'h03FF_FFFF)};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1;
    mem_lat = lat;
    tick();
    pop_log.delete();
    pop_cyc.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_pops(input string tag);
    check({tag, "_count"}, 80'(pop_log.size() >= exp_q.size()), 80'(1));
    if (pop_log.size() >= exp_q.size())
      foreach (exp_q[i]) check(tag, pop_log[i], exp_q[i]);
  endtask

  // ---------------- instruction memory model ----------------
  logic        s_rst, s_fire;
  logic [31:0] s_addr;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_fire = imem_req_valid && imem_req_ready;
      s_addr = imem_req_addr;
      @(posedge clk);
      #1;
      if (s_rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (s_fire) begin
        pend_addr.push_back(s_addr);
        pend_due.push_back(cyc - 1 + mem_lat);
      end
      if (!s_rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // ---------------- compare process: architectural model ----------------
  logic        prev_stall = 1'b0, prev_req_stall = 1'b0, redirect_now;
  logic [31:0] prev_pc, prev_addr, exp_pc, exp_addr;
  logic [79:0] prev_fields;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc         = RESET_PC;
      exp_addr       = RESET_PC;
      prev_stall     = 1'b0;
      prev_req_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 80'(id_valid), 80'(1));
        check("hold_pc", 80'(id_pc), 80'(prev_pc));
        check("hold_fields", fields_now, prev_fields);
      end
      if (prev_req_stall) check("req_addr_hold", 80'(imem_req_addr), 80'(prev_addr));
      if (id_valid) begin
        check("id_pc", 80'(id_pc), 80'(exp_pc));
        check("id_fields", fields_now, model_fields(exp_pc));
      end
      redirect_now = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", 80'(imem_req_addr), 80'(exp_addr));
        exp_addr = exp_addr + 32'd4;
        fire_cnt++;
      end
      if (id_valid && id_ready) begin
        pop_log.push_back(id_pc);
        pop_cyc.push_back(cyc);
        if (ex_pc_next != exp_pc + 32'd4) begin
          redirect_now = 1'b1;
          exp_pc   = {ex_pc_next[31:2], 2'b00};
          exp_addr = exp_pc;
        end else begin
          exp_pc = ex_pc_next;
        end
      end
      prev_stall     = id_valid && !id_ready;
      prev_pc        = id_pc;
      prev_fields    = fields_now;
      prev_req_stall = imem_req_valid && !imem_req_ready && !redirect_now;
      prev_addr      = imem_req_addr;
    end
  end

  // ---------------- directed driver ----------------
  logic [15:0] mr_pat = 16'b1101_0111_0110_1011;
  logic [15:0] ir_pat = 16'b1011_1001_1110_1101;
  int f0;

  initial begin
    // Reset values
    tick(); tick();
    @(negedge clk);
    check("rst_req_valid", 80'(imem_req_valid), 80'(0));
    check("rst_req_addr", 80'(imem_req_addr), 80'(RESET_PC));
    check("rst_id_valid", 80'(id_valid), 80'(0));
    check("rst_id_pc", 80'(id_pc), 80'(0));
    check("rst_fields", fields_now, 80'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 80'(imem_req_valid), 80'(1));
    check("first_req_addr", 80'(imem_req_addr), 80'(0));
    tick();
    @(negedge clk);
    check("lat_not_yet", 80'(id_valid), 80'(0));
    tick();
    @(negedge clk);
    check("lat_valid", 80'(id_valid), 80'(1));
    check("lat_pc", 80'(id_pc), 80'(0));
    check("dec_opcode", 80'(id_opcode), 80'(0));
    check("dec_rs", 80'(id_rs), 80'(4));
    check("dec_rt", 80'(id_rt), 80'(5));
    check("dec_rd", 80'(id_rd), 80'(2));
    check("dec_shamt", 80'(id_shamt), 80'(0));
    check("dec_funct", 80'(id_funct), 80'(6'h20));
    check("dec_imm", 80'(id_immediate), 80'(16'h1020));
    check("dec_jaddr", 80'(id_jaddr), 80'(26'h085_1020));
    repeat (8) tick();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    check_pops("seq");
    if (pop_cyc.size() >= 6) check("throughput", 80'(pop_cyc[5] - pop_cyc[0]), 80'(5));

    // Stall: credit caps requests, outputs hold, resume in order
    id_ready = 1'b0;
    do_reset(1);
    f0 = fire_cnt;
    repeat (10) tick();
    check("stall_fires", 80'(fire_cnt - f0), 80'(DEPTH));
    check("stall_valid", 80'(id_valid), 80'(1));
    check("stall_pc", 80'(id_pc), 80'(0));
    id_ready = 1'b1;
    repeat (10) tick();
    check_pops("resume");

    // Reset with the buffer full
    id_ready = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    pop_log.delete();
    pop_cyc.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstfull_id_valid", 80'(id_valid), 80'(0));
    check("rstfull_req_addr", 80'(imem_req_addr), 80'(RESET_PC));
    check("rstfull_req_valid", 80'(imem_req_valid), 80'(1));
    id_ready = 1'b1;
    repeat (10) tick();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    check_pops("rstfull_restart");

    // Jump at 0x8 to 0x40 with two-cycle memory (two requests in flight)
    jmp_en = 1'b1; jmp_from = 32'h8; jmp_to = 32'h40;
    do_reset(2);
    repeat (20) tick();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48};
    check_pops("jump_lat2");

    // Redirect coinciding with a response and a request; unaligned target
    jmp_to = 32'h102;
    do_reset(1);
    repeat (15) tick();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    check_pops("jump_lat1");
    if (pop_cyc.size() >= 4) check("redirect_penalty", 80'(pop_cyc[3] - pop_cyc[2]), 80'(3));

    // Loop 0x8..0x20 with irregular memory and consumer readiness
    jmp_from = 32'h20; jmp_to = 32'h8;
    do_reset(2);
    for (int k = 0; k < 64; k++) begin
      imem_req_ready = mr_pat[k % 16];
      id_ready       = ir_pat[k % 16];
      tick();
    end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
              32'h20, 32'h8, 32'hC};
    check_pops("loop_bp");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    n_checks++;
    $display("FAIL watchdog: got timeout want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
